// File: rtl/wb_regfile.sv
// Write-back stage latch plus 2-read/1-write register file with WB-to-ID bypass.
// Register 0 is hardwired to zero; wb_count tallies committed writes and wraps silently.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_write_reg_en,
  input  logic [ADDR_W-1:0] ex_write_reg_addr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [15:0]       wb_count
);

  localparam int NREG = 1 << ADDR_W;

  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [15:0]       wb_count_q;
  logic [DATA_W-1:0] regs_q [NREG];
  logic              commit_s;

  // A flush squashes the latched write, so it must not reach the array on that edge.
  assign commit_s = wb_en_q && (wb_addr_q != '0) && !stall && !flush;

  // Stage latch next state: flush beats stall, stall beats load.
  always_comb begin
    wb_en_d   = wb_en_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (flush) begin
      wb_en_d   = 1'b0;
      wb_addr_d = '0;
      wb_data_d = '0;
    end else if (stall) begin
      wb_en_d   = wb_en_q;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
    end else begin
      wb_en_d   = ex_write_reg_en;
      wb_addr_d = ex_write_reg_addr;
      wb_data_d = ex_result;
    end
  end

  // Stage latch registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Register array and commit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_count_q <= 16'h0000;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit_s) begin
      wb_count_q        <= wb_count_q + 16'h0001;
      regs_q[wb_addr_q] <= wb_data_q;
    end else begin
      wb_count_q <= wb_count_q;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] data;
    if (addr == '0) begin
      data = '0;
    end else if (wb_en_q && (wb_addr_q == addr)) begin
      data = wb_data_q;
    end else begin
      data = regs_q[addr];
    end
    return data;
  endfunction

  // Combinational read ports; reset clears all state so they read zero during reset.
  always_comb begin
    rd_data_a = read_port(rd_addr_a);
    rd_data_b = read_port(rd_addr_b);
  end

  assign wb_en    = wb_en_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign wb_count = wb_count_q;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32, shall set the data width of results and registers.
REQ-002 Parameter ADDR_W, default 5, shall set the register address width (32 registers).
REQ-003 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  shall be the asynchronous, active-low reset.
REQ-005 ex_write_reg_en  input  1  shall be the EX-stage register write enable.
REQ-006 ex_write_reg_addr  input  ADDR_W  shall be the EX-stage destination register.
REQ-007 ex_result  input  DATA_W  shall be the EX-stage result.
REQ-008 stall  input  1  shall hold the stage latch when high.
REQ-009 flush  input  1  shall squash the stage latch when high.
REQ-010 rd_addr_a  input  ADDR_W  shall be read port A address (driven by ID).
REQ-011 rd_addr_b  input  ADDR_W  shall be read port B address.
REQ-012 rd_data_a  output  DATA_W  shall be read port A data, combinational.
REQ-013 rd_data_b  output  DATA_W  shall be read port B data, combinational.
REQ-014 wb_en  output  1  shall be the latched write enable.
REQ-015 wb_addr  output  ADDR_W  shall be the latched destination.
REQ-016 wb_data  output  DATA_W  shall be the latched result.
REQ-017 wb_count  output  16  shall count committed register writes.

Function
REQ-018 The stage latch (wb_en, wb_addr, wb_data) shall, on each rising edge: clear wb_en, wb_addr and wb_data to 0 if flush=1; else hold if stall=1; else load ex_write_reg_en, ex_write_reg_addr, ex_result.
REQ-019 flush=1 together with stall=1 shall behave as flush (flush wins).
REQ-020 A write shall commit on a rising edge when wb_en=1, wb_addr!=0 and stall=0: regs[wb_addr]<=wb_data and wb_count<=wb_count+1.
REQ-021 A write under stall=1 shall not commit; it shall commit on the first edge with stall=0 and flush=0.
REQ-022 A latched write shall not commit on an edge with flush=1; flush squashes it.
REQ-023 wb_addr=0 shall never modify register 0 or increment wb_count.
REQ-024 wb_count shall wrap from 16'hFFFF to 16'h0000 without a flag.
REQ-025 A read port with address 0 shall return 0.
REQ-026 A read port with address equal to wb_addr, when wb_en=1 and wb_addr!=0, shall return wb_data (bypass).
REQ-027 Otherwise a read port shall return regs[address].
REQ-028 Latency: an EX result shall be visible on a read port via bypass after 1 rising edge, and from the array after 2 edges, given stall=0.
REQ-029 Both read ports shall operate independently; identical addresses on both ports shall return identical data.
REQ-030 Read ports shall have no clock dependency beyond the latch and array state.

Reset
REQ-031 rst=0 shall asynchronously clear wb_en, wb_addr, wb_data, wb_count and all 32 registers to 0.
REQ-032 While rst=0, rd_data_a and rd_data_b shall read 0 for every address.
REQ-033 Reset asserted mid-stall or with a write pending shall discard the pending write.
REQ-034 The first latch load shall occur on the first rising edge after rst deasserts.

Verification
REQ-035 Write-back: drive en=1, addr=5, result=32'h1234_5678 for one cycle, then en=0 -> rd_addr_a=5 returns 32'h1234_5678 after edge 1 via bypass and after edge 2 from the array; wb_count=1.
REQ-036 Zero register: drive en=1, addr=0, result=32'hFFFF_FFFF -> rd_data_a at address 0 stays 0; wb_count unchanged.
REQ-037 Stall/flush: latch addr=7, data=32'hA5A5_A5A5, hold stall=1 for 3 cycles -> rd_data_a at address 7 shows the bypass value while the array holds 0 and wb_count is unchanged; assert flush with stall -> wb_en=0, no commit, and rd_data_a at address 7 returns 0.
REQ-038 Back-to-back: write addr=3 with 32'h1 then addr=3 with 32'h2 on consecutive cycles -> rd_data_b at address 3 reads 32'h2 via bypass, then 32'h2 from the array.
REQ-039 Reset mid-operation: with regs 1..4 written and a write to addr=9 pending under stall, pull rst low between edges -> all outputs and reads are 0 immediately and wb_count=0.
REQ-040 Counter wrap: preload wb_count to 16'hFFFF via 65535 writes, then perform one more write -> wb_count=16'h0000.
